branch_resolve: RTL and testbench

- Consumer end of the execute-stage flag/branch-target interface in the 16-bit pipelined core.
- Latches the V/Z/N flags produced by flag-setting ALU ops.
- Evaluates the 3-bit branch condition against the latched flags and issues a registered one-cycle PC redirect to fetch, carrying the branch target (or the register target for JR).
- Squashes the two wrong-path instructions that follow a taken branch, and keeps saturating branch/taken counters.

---
 rtl/branch_resolve.sv | 149 ++++++++++++++
 tb/tb_branch_resolve.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: latches ALU flags, evaluates branch conditions,
// issues a one-cycle fetch redirect, squashes wrong-path slots and counts branches.
module branch_resolve #(
   parameter int SQUASH_DEPTH = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic             set_flags,
   input  logic             v_in,
   input  logic             z_in,
   input  logic             n_in,
   input  logic             is_branch,
   input  logic [2:0]       cond,
   input  logic [15:0]      branch_target,
   input  logic             is_jr,
   input  logic [15:0]      jr_target,
   input  logic             clr_cnt,
   output logic [2:0]       flags_q,
   output logic             redirect,
   output logic [15:0]      redirect_pc,
   output logic             squash,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [0:0] {RUN = 1'b0, SQUASH = 1'b1} state_t;

   localparam logic [1:0] DEPTH = 2'(SQUASH_DEPTH);

   state_t      state_r, state_s;
   logic [1:0]  sq_cnt_r, sq_cnt_s;
   logic        accepted_s;
   logic        cond_true_s;
   logic        taken_s;
   logic [15:0] target_s;

   // flags_q holds {V,Z,N}
   function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
      logic v, z, n, r;
      v = f[2];
      z = f[1];
      n = f[0];
      case (c)
         3'd0:    r = ~z;
         3'd1:    r = z;
         3'd2:    r = ~z & ~n;
         3'd3:    r = n;
         3'd4:    r = z | ~n;
         3'd5:    r = z | n;
         3'd6:    r = v;
         3'd7:    r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
      logic [CNT_W-1:0] r;
      if (inc && (c != {CNT_W{1'b1}})) begin
         r = c + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r = c;
      end
      return r;
   endfunction

   assign squash      = (state_r == SQUASH);
   assign accepted_s  = ex_valid & ~stall & ~squash;
   assign cond_true_s = cond_eval(cond, flags_q);
   assign taken_s     = accepted_s & (is_jr | (is_branch & cond_true_s));
   assign target_s    = is_jr ? jr_target : branch_target;

   // Next-state logic for the wrong-path squash window
   always_comb begin
      state_s  = state_r;
      sq_cnt_s = sq_cnt_r;
      case (state_r)
         RUN: begin
            if (taken_s) begin
               state_s  = SQUASH;
               sq_cnt_s = DEPTH;
            end else begin
               state_s  = RUN;
               sq_cnt_s = 2'd0;
            end
         end
         SQUASH: begin
            if (stall) begin
               sq_cnt_s = sq_cnt_r;
            end else if (sq_cnt_r <= 2'd1) begin
               state_s  = RUN;
               sq_cnt_s = 2'd0;
            end else begin
               sq_cnt_s = sq_cnt_r - 2'd1;
            end
         end
         default: begin
            state_s  = RUN;
            sq_cnt_s = 2'd0;
         end
      endcase
   end

   // State and squash counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= RUN;
         sq_cnt_r <= 2'd0;
      end else begin
         state_r  <= state_s;
         sq_cnt_r <= sq_cnt_s;
      end
   end

   // Flag latch and redirect pulse; the pulse drops regardless of stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q     <= 3'b000;
         redirect    <= 1'b0;
         redirect_pc <= 16'h0000;
      end else begin
         if (accepted_s && set_flags) begin
            flags_q <= {v_in, z_in, n_in};
         end
         redirect <= taken_s;
         if (taken_s) begin
            redirect_pc <= target_s;
         end
      end
   end

   // Saturating performance counters; clear wins over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt    <= {CNT_W{1'b0}};
         taken_cnt <= {CNT_W{1'b0}};
      end else if (clr_cnt) begin
         br_cnt    <= {CNT_W{1'b0}};
         taken_cnt <= {CNT_W{1'b0}};
      end else begin
         br_cnt    <= sat_inc(br_cnt, accepted_s & (is_branch | is_jr));
         taken_cnt <= sat_inc(taken_cnt, taken_s);
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_branch_resolve;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, ex_valid, set_flags, v_in, z_in, n_in, is_branch, is_jr, clr_cnt;
   logic [2:0]  cond;
   logic [15:0] branch_target, jr_target;
   logic [2:0]  flags_q;
   logic        redirect, squash;
   logic [15:0] redirect_pc;
   logic [15:0] br_cnt, taken_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_flags, m_redir, m_pc, m_sq, m_br, m_tk;

   branch_resolve #(.SQUASH_DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .set_flags(set_flags),
      .v_in(v_in), .z_in(z_in), .n_in(n_in), .is_branch(is_branch), .cond(cond),
      .branch_target(branch_target), .is_jr(is_jr), .jr_target(jr_target),
      .clr_cnt(clr_cnt), .flags_q(flags_q), .redirect(redirect),
      .redirect_pc(redirect_pc), .squash(squash), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("flags_q", int'(flags_q), m_flags);
      chk("redirect", int'(redirect), m_redir);
      chk("redirect_pc", int'(redirect_pc), m_pc);
      chk("squash", int'(squash), (m_sq > 0) ? 1 : 0);
      chk("br_cnt", int'(br_cnt), m_br);
      chk("taken_cnt", int'(taken_cnt), m_tk);
   endtask

   task automatic model_reset();
      m_flags = 0; m_redir = 0; m_pc = 0; m_sq = 0; m_br = 0; m_tk = 0;
   endtask

   task automatic idle();
      stall = 1'b0; ex_valid = 1'b0; set_flags = 1'b0; v_in = 1'b0; z_in = 1'b0;
      n_in = 1'b0; is_branch = 1'b0; is_jr = 1'b0; clr_cnt = 1'b0; cond = 3'd0;
      branch_target = 16'h0000; jr_target = 16'h0000;
   endtask

   // Apply current inputs for one clock, advance the model, compare
   task automatic step();
      bit acc, ct, tk, z, n, v;
      z = m_flags[1]; n = m_flags[0]; v = m_flags[2];
      acc = ex_valid && !stall && (m_sq == 0);
      case (cond)
         3'd0: ct = !z;
         3'd1: ct = z;
         3'd2: ct = !z && !n;
         3'd3: ct = n;
         3'd4: ct = z || !n;
         3'd5: ct = z || n;
         3'd6: ct = v;
         default: ct = 1'b1;
      endcase
      tk = acc && (is_jr || (is_branch && ct));
      @(posedge clk);
      #1;
      if (acc && set_flags) m_flags = {v_in, z_in, n_in};
      m_redir = tk ? 1 : 0;
      if (tk) m_pc = is_jr ? int'(jr_target) : int'(branch_target);
      if (tk) m_sq = DEPTH;
      else if (m_sq > 0 && !stall) m_sq = m_sq - 1;
      if (clr_cnt) begin
         m_br = 0; m_tk = 0;
      end else begin
         if (acc && (is_branch || is_jr) && m_br < 65535) m_br++;
         if (tk && m_tk < 65535) m_tk++;
      end
      check_all();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();

      // ADD sets {V,Z,N}={0,1,0}, then BEQ taken to 0x0040
      ex_valid = 1'b1; set_flags = 1'b1; z_in = 1'b1;
      step();
      chk("plan1_flags", int'(flags_q), 3'b010);
      idle(); ex_valid = 1'b1; is_branch = 1'b1; cond = 3'd1; branch_target = 16'h0040;
      step();
      chk("plan1_redirect", int'(redirect), 1);
      chk("plan1_pc", int'(redirect_pc), 16'h0040);
      idle(); ex_valid = 1'b1;
      step();
      chk("plan1_pulse_end", int'(redirect), 0);
      chk("plan1_squash_a", int'(squash), 1);
      step();
      chk("plan1_squash_b", int'(squash), 0);
      chk("plan1_br_cnt", int'(br_cnt), 1);
      chk("plan1_taken_cnt", int'(taken_cnt), 1);

      // Clear flags then BEQ not taken
      idle(); ex_valid = 1'b1; set_flags = 1'b1;
      step();
      idle(); ex_valid = 1'b1; is_branch = 1'b1; cond = 3'd1; branch_target = 16'h0100;
      step();
      chk("plan2_no_redirect", int'(redirect), 0);
      chk("plan2_br_cnt", int'(br_cnt), 2);
      chk("plan2_taken_cnt", int'(taken_cnt), 1);

      // Taken branch, flag writes during squash are dropped
      idle(); ex_valid = 1'b1; is_branch = 1'b1; cond = 3'd7; branch_target = 16'h0200;
      step();
      idle(); ex_valid = 1'b1; set_flags = 1'b1; v_in = 1'b1; z_in = 1'b1; n_in = 1'b1;
      step();
      step();
      chk("plan3_flags_held", int'(flags_q), 3'b000);
      step();
      chk("plan3_flags_new", int'(flags_q), 3'b111);

      // JR + branch together, stall on next cycle
      idle(); ex_valid = 1'b1; is_jr = 1'b1; is_branch = 1'b1; cond = 3'd1;
      jr_target = 16'h1234; branch_target = 16'h0ABC;
      step();
      chk("plan4_pc", int'(redirect_pc), 16'h1234);
      idle(); stall = 1'b1; ex_valid = 1'b1;
      step();
      chk("plan4_single_pulse", int'(redirect), 0);
      chk("plan4_squash_stalled", int'(squash), 1);
      idle(); ex_valid = 1'b1;
      step();
      chk("plan4_squash_2", int'(squash), 1);
      step();
      chk("plan4_squash_done", int'(squash), 0);

      // Saturate br_cnt with not-taken branches (flags now all zero? force EQ false)
      idle(); ex_valid = 1'b1; set_flags = 1'b1; clr_cnt = 1'b1;
      step();
      idle(); ex_valid = 1'b1; is_branch = 1'b1; cond = 3'd1;
      for (int i = 0; i < 65535; i++) step();
      chk("plan5_preload", int'(br_cnt), 16'hFFFF);
      step();
      chk("plan5_saturated", int'(br_cnt), 16'hFFFF);
      idle(); ex_valid = 1'b1; is_branch = 1'b1; cond = 3'd7; clr_cnt = 1'b1;
      step();
      chk("plan5_clr_br", int'(br_cnt), 0);
      chk("plan5_clr_tk", int'(taken_cnt), 0);

      // Async reset mid-squash while redirect is high
      #2;
      chk("plan6_pre_squash", int'(squash), 1);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 1'b0;
      idle(); ex_valid = 1'b1; set_flags = 1'b1; v_in = 1'b1; n_in = 1'b1;
      step();
      chk("plan6_accepted", int'(flags_q), 3'b101);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         stall         = ($urandom_range(0, 4) == 0);
         ex_valid      = ($urandom_range(0, 5) != 0);
         set_flags     = $urandom_range(0, 1);
         v_in          = $urandom_range(0, 1);
         z_in          = $urandom_range(0, 1);
         n_in          = $urandom_range(0, 1);
         is_branch     = $urandom_range(0, 1);
         is_jr         = ($urandom_range(0, 7) == 0);
         cond          = 3'($urandom_range(0, 7));
         branch_target = 16'($urandom);
         jr_target     = 16'($urandom);
         clr_cnt       = ($urandom_range(0, 30) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
